phase_mux_n: RTL and testbench
==============================

# phase_mux_n

Registered N-channel, W-bit phase selector for the traffic-light datapath. It routes one of N light-pattern words to the lamp driver outputs. On every change of the selected channel it inserts a configurable all-off blanking interval, so two phases never drive lamps in adjacent cycles. Channel changes use a request/acknowledge handshake with the controller FSM.

## Interface
Parameters:
- N, default 4: number of input channels; N ≥ 2.
- W, default 3: bits per channel word.
- BLANK, default 2: all-off cycles inserted on a channel change; 0 disables blanking.
- SW, default $clog2(N): select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- d  in  N*W  flattened channel words; channel i occupies d[i*W +: W].
- sel  in  SW  requested channel index.
- sel_req  in  1  request to switch to sel; sampled on rising edges.
- sel_ack  out  1  one-cycle pulse when the request is honoured.
- sel_err  out  1  one-cycle pulse when a request carries sel ≥ N.
- busy  out  1  high while blanking.
- cur_sel  out  SW  currently committed channel.
- y  out  W  registered output word.

## Operation
- Reset values: y=0, cur_sel=0, sel_ack=0, sel_err=0, busy=0, state=HOLD, blank counter=0, queue empty.
- State HOLD:
  - Each edge: y ← d[cur_sel].
  - sel_req with sel ≥ N: sel_err=1 for one cycle; no other change.
  - sel_req with sel == cur_sel: sel_ack=1 next cycle; no blanking; y continues.
  - sel_req with a valid sel ≠ cur_sel and BLANK ≥ 1: latch pend←sel, cnt←BLANK−1, y←0, busy←1, go to BLANK.
  - Same request with BLANK=0: cur_sel←sel, y←d[sel], sel_ack=1 on that edge.
- State BLANK:
  - y held at 0.
  - When cnt≠0, each edge decrements cnt.
  - When cnt==0, the edge sets cur_sel←pend, y←d[pend], sel_ack←1, busy←0 and returns to HOLD.
  - sel_req here is handled as described under Configuration.
- sel_ack and sel_err are never high in the same cycle.
- d may change at any time; only the selected channel is captured, once per cycle.
- Asynchronous reset mid-blank: immediate return to reset values; pending and queued requests are discarded.

## Timing
- Data latency: 1 cycle from d to y in HOLD.
- Switch latency with request sampled at edge E0:
  - y=0 after E0 through E(BLANK−1), i.e. exactly BLANK cycles.
  - y=d[new], cur_sel=new and sel_ack=1 after E(BLANK).
  - sel_ack is high for the single cycle following E(BLANK).
- busy is high from after E0 until E(BLANK), i.e. BLANK cycles.
- Same-channel and BLANK=0 requests: ack one cycle after sampling.
- sel_req held high continuously is treated as a new request each HOLD cycle. The controller deasserts it on sel_ack.

## Configuration
- PHASE_MUX_REQ_QUEUE_EN defined:
  - A valid sel_req sampled in BLANK is stored in a one-deep queue; a later request overwrites it.
  - An invalid sel_req raises sel_err and is not queued.
  - On the edge that returns to HOLD, the queued request is evaluated on the following edge exactly as if sel_req were high in that HOLD cycle; the queue then clears.
- PHASE_MUX_REQ_QUEUE_EN undefined:
  - sel_req during BLANK is ignored: no ack, no error, no state change.
  - An invalid sel during BLANK is also ignored.

## Test plan
Bench parameters: N=4, W=3, BLANK=2, d = {ch3=3'b100, ch2=3'b010, ch1=3'b001, ch0=3'b110}.
- Reset, then no request → y=3'b110 one cycle after reset release; cur_sel=0; busy=0.
- sel=2 with a 1-cycle sel_req → y=0 for 2 cycles with busy=1; then y=3'b010, cur_sel=2, one sel_ack pulse.
- sel=0 while cur_sel=0 → sel_ack next cycle; y stays 3'b110; busy never rises.
- sel=5 is unrepresentable with N=4. Rerun with N=3 and sel=3 → sel_err pulse, no ack, cur_sel unchanged.
- Request ch1, then during BLANK request ch3:
  - Queue disabled: ends on ch1, single ack.
  - Queue enabled: ch1 ack, then a further 2-cycle blank, then y=3'b100 with a second ack.
- Assert reset during BLANK → y=0, cur_sel=0, busy=0 immediately; no ack after release.

Source files
------------

// File: rtl/phase_mux_n.sv
// phase_mux_n: registered N-channel phase selector that blanks the lamps for BLANK cycles on a channel change.
// Define PHASE_MUX_REQ_QUEUE_EN to keep a one-deep queue of requests that arrive during blanking.
module phase_mux_n #(
  parameter int N     = 4,
  parameter int W     = 3,
  parameter int BLANK = 2,
  parameter int SW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  d,
  input  logic [SW-1:0]   sel,
  input  logic            sel_req,
  output logic            sel_ack,
  output logic            sel_err,
  output logic            busy,
  output logic [SW-1:0]   cur_sel,
  output logic [W-1:0]    y
);

  localparam int CW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [SW:0]   N_L      = (SW+1)'(N);
  localparam logic [CW-1:0] CNT_INIT = (BLANK > 0) ? CW'(BLANK - 1) : {CW{1'b0}};

  typedef enum logic [0:0] {ST_HOLD = 1'b0, ST_BLANK = 1'b1} state_t;

  state_t          state_r, state_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;
  logic [SW-1:0]   pend_r, pend_nxt;
  logic [SW-1:0]   cur_sel_r, cur_nxt;
  logic [W-1:0]    y_r, y_nxt;
  logic            ack_r, ack_nxt;
  logic            err_r, err_nxt;
  logic            busy_r, busy_nxt;
  logic            req_s;
  logic [SW-1:0]   req_sel_s;
  logic            req_ok_s;

  function automatic logic [W-1:0] chan_word(input logic [N*W-1:0] dv, input logic [SW-1:0] idx);
    logic [W-1:0] res;
    res = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (idx == SW'(i)) res = dv[i*W +: W];
    end
    return res;
  endfunction

`ifdef PHASE_MUX_REQ_QUEUE_EN
  logic            q_valid_r, q_valid_nxt;
  logic [SW-1:0]   q_sel_r, q_sel_nxt;
  logic            sel_ok_s;

  assign sel_ok_s = ({1'b0, sel} < N_L);

  // A queued request stands in for sel_req in the first HOLD cycle after blanking
  always_comb begin
    if (q_valid_r) begin
      req_s     = 1'b1;
      req_sel_s = q_sel_r;
    end else begin
      req_s     = sel_req;
      req_sel_s = sel;
    end
  end
`else
  assign req_s     = sel_req;
  assign req_sel_s = sel;
`endif

  assign req_ok_s = ({1'b0, req_sel_s} < N_L);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_HOLD;
    else       state_r <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_HOLD: begin
        if (req_s && req_ok_s && (req_sel_s != cur_sel_r) && (BLANK > 0)) state_nxt = ST_BLANK;
        else state_nxt = ST_HOLD;
      end
      ST_BLANK: begin
        if (cnt_r == {CW{1'b0}}) state_nxt = ST_HOLD;
        else state_nxt = ST_BLANK;
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  // Datapath and handshake next values
  always_comb begin
    y_nxt    = y_r;
    cur_nxt  = cur_sel_r;
    pend_nxt = pend_r;
    cnt_nxt  = cnt_r;
    ack_nxt  = 1'b0;
    err_nxt  = 1'b0;
    busy_nxt = busy_r;
`ifdef PHASE_MUX_REQ_QUEUE_EN
    q_valid_nxt = q_valid_r;
    q_sel_nxt   = q_sel_r;
`endif
    case (state_r)
      ST_HOLD: begin
        y_nxt    = chan_word(d, cur_sel_r);
        busy_nxt = 1'b0;
`ifdef PHASE_MUX_REQ_QUEUE_EN
        q_valid_nxt = 1'b0;
`endif
        if (req_s && !req_ok_s) begin
          err_nxt = 1'b1;
        end else if (req_s && (req_sel_s == cur_sel_r)) begin
          ack_nxt = 1'b1;
        end else if (req_s) begin
          if (BLANK > 0) begin
            pend_nxt = req_sel_s;
            cnt_nxt  = CNT_INIT;
            y_nxt    = {W{1'b0}};
            busy_nxt = 1'b1;
          end else begin
            cur_nxt = req_sel_s;
            y_nxt   = chan_word(d, req_sel_s);
            ack_nxt = 1'b1;
          end
        end else begin
          ack_nxt = 1'b0;
        end
      end
      ST_BLANK: begin
        y_nxt = {W{1'b0}};
        if (cnt_r == {CW{1'b0}}) begin
          cur_nxt  = pend_r;
          y_nxt    = chan_word(d, pend_r);
          ack_nxt  = 1'b1;
          busy_nxt = 1'b0;
        end else begin
          cnt_nxt  = cnt_r - CW'(1'b1);
          busy_nxt = 1'b1;
        end
`ifdef PHASE_MUX_REQ_QUEUE_EN
        // On the returning edge the ack wins; an invalid request there is dropped
        if (sel_req && sel_ok_s) begin
          q_valid_nxt = 1'b1;
          q_sel_nxt   = sel;
        end else if (sel_req && !ack_nxt) begin
          err_nxt = 1'b1;
        end else begin
          q_valid_nxt = q_valid_r;
        end
`endif
      end
      default: begin
        y_nxt    = {W{1'b0}};
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Registered datapath, handshake and queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CW{1'b0}};
      pend_r    <= {SW{1'b0}};
      cur_sel_r <= {SW{1'b0}};
      y_r       <= {W{1'b0}};
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
`ifdef PHASE_MUX_REQ_QUEUE_EN
      q_valid_r <= 1'b0;
      q_sel_r   <= {SW{1'b0}};
`endif
    end else begin
      cnt_r     <= cnt_nxt;
      pend_r    <= pend_nxt;
      cur_sel_r <= cur_nxt;
      y_r       <= y_nxt;
      ack_r     <= ack_nxt;
      err_r     <= err_nxt;
      busy_r    <= busy_nxt;
`ifdef PHASE_MUX_REQ_QUEUE_EN
      q_valid_r <= q_valid_nxt;
      q_sel_r   <= q_sel_nxt;
`endif
    end
  end

  assign y       = y_r;
  assign cur_sel = cur_sel_r;
  assign sel_ack = ack_r;
  assign sel_err = err_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_phase_mux_n.sv
// Self-checking bench for phase_mux_n: per-cycle expected outputs are queued with the stimulus and popped after each edge.
module tb_phase_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] d;
  logic [1:0]  sel;
  logic        sel_req;
  logic        sel_ack, sel_err, busy;
  logic [1:0]  cur_sel;
  logic [2:0]  y;

  logic [8:0]  d3;
  logic [1:0]  sel3;
  logic        sel_req3;
  logic        sel_ack3, sel_err3, busy3;
  logic [1:0]  cur_sel3;
  logic [2:0]  y3;

  phase_mux_n #(.N(4), .W(3), .BLANK(2)) dut (
    .clk(clk), .reset(reset), .d(d), .sel(sel), .sel_req(sel_req),
    .sel_ack(sel_ack), .sel_err(sel_err), .busy(busy), .cur_sel(cur_sel), .y(y)
  );

  phase_mux_n #(.N(3), .W(3), .BLANK(2)) dut3 (
    .clk(clk), .reset(reset), .d(d3), .sel(sel3), .sel_req(sel_req3),
    .sel_ack(sel_ack3), .sel_err(sel_err3), .busy(busy3), .cur_sel(cur_sel3), .y(y3)
  );

`ifdef PHASE_MUX_REQ_QUEUE_EN
  localparam logic [1:0] CUR_AFTER = 2'd3;
  localparam logic [2:0] CUR_WORD  = 3'b100;
  localparam logic       QERR      = 1'b1;
`else
  localparam logic [1:0] CUR_AFTER = 2'd1;
  localparam logic [2:0] CUR_WORD  = 3'b001;
  localparam logic       QERR      = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Observed/expected layout: {y[2:0], cur_sel[1:0], busy, sel_ack, sel_err}
  logic [7:0] exp_q[$];
  logic [2:0] stim_q[$];

  task automatic test_reset();
    logic [7:0] ev, ov;
    reset = 1'b1; sel_req = 1'b0; sel = 2'd0; sel_req3 = 1'b0; sel3 = 2'd0;
    d  = {3'b100, 3'b010, 3'b001, 3'b110};
    d3 = {3'b010, 3'b001, 3'b110};
    @(posedge clk); @(posedge clk); #1;
    ov = {y, cur_sel, busy, sel_ack, sel_err};
    n_checks++;
    if (ov !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %b want %b", ov, 8'h00); end
    reset = 1'b0;
    repeat (2) begin
      stim_q.push_back({1'b0, 2'd0});
      exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b0, 1'b0});
    end
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL reset_release: got %b want %b", ov, ev); end
    end
  endtask

  task automatic test_same_channel();
    logic [7:0] ev, ov;
    stim_q.push_back({1'b1, 2'd0}); exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b1, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b0, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL same_channel: got %b want %b", ov, ev); end
    end
  endtask

  task automatic test_switch();
    logic [7:0] ev, ov;
    stim_q.push_back({1'b1, 2'd2}); exp_q.push_back({3'b000, 2'd0, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b000, 2'd0, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b010, 2'd2, 1'b0, 1'b1, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b010, 2'd2, 1'b0, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL switch: got %b want %b", ov, ev); end
    end
  endtask

  task automatic test_request_in_blank();
    logic [7:0] ev, ov;
    stim_q.push_back({1'b1, 2'd1}); exp_q.push_back({3'b000, 2'd2, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b1, 2'd3}); exp_q.push_back({3'b000, 2'd2, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b001, 2'd1, 1'b0, 1'b1, 1'b0});
`ifdef PHASE_MUX_REQ_QUEUE_EN
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b000, 2'd1, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b000, 2'd1, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b100, 2'd3, 1'b0, 1'b1, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b100, 2'd3, 1'b0, 1'b0, 1'b0});
`else
    repeat (4) begin
      stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b001, 2'd1, 1'b0, 1'b0, 1'b0});
    end
`endif
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL request_in_blank: got %b want %b", ov, ev); end
    end
  endtask

  task automatic test_data_latency();
    logic [7:0] ev, ov;
    d[int'(CUR_AFTER)*3 +: 3] = 3'b111;
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b111, CUR_AFTER, 1'b0, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL data_latency: got %b want %b", ov, ev); end
    end
    d[int'(CUR_AFTER)*3 +: 3] = CUR_WORD;
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({CUR_WORD, CUR_AFTER, 1'b0, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL data_restore: got %b want %b", ov, ev); end
    end
  endtask

  task automatic test_reset_in_blank();
    logic [7:0] ev, ov;
    stim_q.push_back({1'b1, 2'd0}); exp_q.push_back({3'b000, CUR_AFTER, 1'b1, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL blank_before_reset: got %b want %b", ov, ev); end
    end
    sel_req = 1'b0;
    reset = 1'b1;
    #1;
    ov = {y, cur_sel, busy, sel_ack, sel_err};
    n_checks++;
    if (ov !== 8'h00) begin n_fail++; $display("FAIL async_reset_mid_blank: got %b want %b", ov, 8'h00); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b0, 1'b0});
    end
    while (stim_q.size() > 0) begin
      {sel_req, sel} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y, cur_sel, busy, sel_ack, sel_err};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL after_reset_no_ack: got %b want %b", ov, ev); end
    end
  endtask

  task automatic test_invalid_sel();
    logic [7:0] ev, ov;
    stim_q.push_back({1'b1, 2'd3}); exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b0, 1'b1});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b110, 2'd0, 1'b0, 1'b0, 1'b0});
    stim_q.push_back({1'b1, 2'd1}); exp_q.push_back({3'b000, 2'd0, 1'b1, 1'b0, 1'b0});
    stim_q.push_back({1'b1, 2'd3}); exp_q.push_back({3'b000, 2'd0, 1'b1, 1'b0, QERR});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b001, 2'd1, 1'b0, 1'b1, 1'b0});
    stim_q.push_back({1'b0, 2'd0}); exp_q.push_back({3'b001, 2'd1, 1'b0, 1'b0, 1'b0});
    while (stim_q.size() > 0) begin
      {sel_req3, sel3} = stim_q.pop_front();
      @(posedge clk); #1;
      ev = exp_q.pop_front();
      ov = {y3, cur_sel3, busy3, sel_ack3, sel_err3};
      n_checks++;
      if (ov !== ev) begin n_fail++; $display("FAIL invalid_sel_n3: got %b want %b", ov, ev); end
    end
    sel_req3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_same_channel();
    test_switch();
    test_request_in_blank();
    test_data_latency();
    test_reset_in_blank();
    test_invalid_sel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
